// File: rtl/mire_gen.sv
// mire_gen - test-pattern generator and Wishbone write master.
//
// Writes one frame of HDISP x VDISP pixels (0x00RRGGBB) starting at byte
// address BASE_ADR, then starts the next frame. Each bus cycle carries at
// most BURST acknowledged beats. Every bus cycle is followed by exactly one
// idle cycle.
//
// Patterns (mode, sampled at frame start):
//   0 grid, 1 colour bars, 2 horizontal gray ramp, 3 solid colour
//
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset
//   en           run request. A burst that has started always completes.
//   mode, color  pattern select and mode-3 colour, latched at frame start
//   wshb_*       Wishbone master write port (byte addresses)
//   frame_done   one-cycle pulse after the last pixel of a frame is acked
//
// Build option:
//   MIRE_GEN_CTI_EN  defined: wshb_cti is 3'b010 on every beat and 3'b111 on
//                    the last beat of each bus cycle.
//                    undefined: wshb_cti is 3'b000 (classic cycles).
//
// State table:
//   state   | meaning
//   S_IDLE  | bus idle, waiting for en
//   S_BURST | cyc/stb high, one pixel per ack
//   S_GAP   | single idle cycle between bus cycles; frame-start relatch
module mire_gen #(
  parameter int          HDISP    = 800,
  parameter int          VDISP    = 480,
  parameter int          BURST    = 64,
  parameter int          GRID     = 16,
  parameter logic [31:0] BASE_ADR = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [1:0]  mode,
  input  logic [23:0] color,
  output logic        wshb_cyc,
  output logic        wshb_stb,
  output logic        wshb_we,
  output logic [3:0]  wshb_sel,
  output logic [31:0] wshb_adr,
  output logic [31:0] wshb_dat_ms,
  output logic [2:0]  wshb_cti,
  output logic [1:0]  wshb_bte,
  input  logic        wshb_ack,
  output logic        frame_done
);

  localparam int XW = (HDISP > 1) ? $clog2(HDISP) : 1;
  localparam int YW = (VDISP > 1) ? $clog2(VDISP) : 1;
  localparam int BW = (BURST > 1) ? $clog2(BURST) : 1;

  typedef enum logic [1:0] {S_IDLE, S_BURST, S_GAP} state_t;

  state_t      state, state_nxt;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [BW-1:0] beat;
  logic [31:0] adr;
  logic [1:0]  mode_q;
  logic [23:0] color_q;
  logic        frame_done_q;

  logic ack_ok, x_last, y_last, px_last, burst_end, at_origin, latch;

  // Acks outside a bus cycle are ignored.
  assign ack_ok    = (state == S_BURST) && wshb_ack;
  assign x_last    = (x == XW'(HDISP - 1));
  assign y_last    = (y == YW'(VDISP - 1));
  assign px_last   = x_last && y_last;
  assign burst_end = (beat == BW'(BURST - 1)) || px_last;
  assign at_origin = (x == '0) && (y == '0);

  // In GAP the position can only be the origin right after a frame wrap,
  // because at least one pixel was acked in the preceding burst.
  assign latch = ((state == S_IDLE) && en && at_origin) ||
                 ((state == S_GAP) && at_origin);

  // state register and datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      x            <= '0;
      y            <= '0;
      beat         <= '0;
      adr          <= BASE_ADR;
      mode_q       <= 2'd0;
      color_q      <= 24'd0;
      frame_done_q <= 1'b0;
    end else begin
      state        <= state_nxt;
      frame_done_q <= ack_ok && px_last;

      if (latch) begin
        mode_q  <= mode;
        color_q <= color;
      end

      if (state == S_GAP)
        beat <= '0;
      else if (ack_ok)
        beat <= beat + 1'b1;

      if (ack_ok) begin
        adr <= px_last ? BASE_ADR : adr + 32'd4;
        if (x_last) begin
          x <= '0;
          y <= y_last ? '0 : y + 1'b1;
        end else begin
          x <= x + 1'b1;
        end
      end
    end
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (en) state_nxt = S_BURST;
      S_BURST: if (ack_ok && burst_end) state_nxt = S_GAP;
      S_GAP:   state_nxt = en ? S_BURST : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // bus outputs
  always_comb begin
    wshb_cyc = (state == S_BURST);
    wshb_stb = (state == S_BURST);
    wshb_cti = 3'b000;
`ifdef MIRE_GEN_CTI_EN
    if (state == S_BURST)
      wshb_cti = burst_end ? 3'b111 : 3'b010;
`endif
  end

  assign wshb_we    = 1'b1;
  assign wshb_sel   = 4'hF;
  assign wshb_bte   = 2'b00;
  assign wshb_adr   = adr;
  assign frame_done = frame_done_q;

  // pixel data, purely a function of position and latched settings
  logic [2:0] bar;
  logic [7:0] gray;
  logic       grid_hit;

  always_comb begin
    grid_hit = ((32'(x) & 32'(GRID - 1)) == 32'd0) ||
               ((32'(y) & 32'(GRID - 1)) == 32'd0);
    bar      = 3'((32'(x) * 32'd8) / 32'(HDISP));
    gray     = 8'(x);
    case (mode_q)
      2'd0:    wshb_dat_ms = grid_hit ? 32'h00FF_FFFF : 32'h0;
      2'd1:    wshb_dat_ms = {8'h00, {8{bar[2]}}, {8{bar[1]}}, {8{bar[0]}}};
      2'd2:    wshb_dat_ms = {8'h00, gray, gray, gray};
      default: wshb_dat_ms = {8'h00, color_q};
    endcase
  end

endmodule

// File: tb/tb_mire_gen.sv
module tb_mire_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, en = 1'b0, ack = 1'b0, force_ack = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [23:0] color = 24'd0;
  logic        cyc, stb, we, frame_done;
  logic [3:0]  sel;
  logic [31:0] adr, dat;
  logic [2:0]  cti;
  logic [1:0]  bte;

  logic        en2 = 1'b1, ack2 = 1'b0;
  logic [1:0]  mode2 = 2'd0;
  logic [23:0] color2 = 24'd0;
  logic        cyc2, stb2, we2, fd2;
  logic [3:0]  sel2;
  logic [31:0] adr2, dat2;
  logic [2:0]  cti2;
  logic [1:0]  bte2;

  mire_gen #(.HDISP(32), .VDISP(4), .BURST(8), .GRID(16), .BASE_ADR(32'h0)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .color(color),
    .wshb_cyc(cyc), .wshb_stb(stb), .wshb_we(we), .wshb_sel(sel),
    .wshb_adr(adr), .wshb_dat_ms(dat), .wshb_cti(cti), .wshb_bte(bte),
    .wshb_ack(ack), .frame_done(frame_done));

  mire_gen #(.HDISP(32), .VDISP(4), .BURST(24), .GRID(16), .BASE_ADR(32'h0)) dut24 (
    .clk(clk), .rst(rst), .en(en2), .mode(mode2), .color(color2),
    .wshb_cyc(cyc2), .wshb_stb(stb2), .wshb_we(we2), .wshb_sel(sel2),
    .wshb_adr(adr2), .wshb_dat_ms(dat2), .wshb_cti(cti2), .wshb_bte(bte2),
    .wshb_ack(ack2), .frame_done(fd2));

  int total = 0, bad = 0;
  int ack_pct = 100;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // slave: decides ack shortly after each edge, so it is stable at the next one
  always @(posedge clk) begin
    #1;
    ack  = force_ack || (stb && ($urandom_range(99) < ack_pct));
    ack2 = stb2;
  end

  // monitor for the BURST=8 instance
  logic [31:0] mem [128];
  logic [31:0] golden [128];
  logic [31:0] exp_adr = 0, prev_adr = 0, prev_dat = 0, last_ack_adr = 0;
  logic        prev_stall = 0, prev_stb = 0, prev_final = 0, chk_gap = 0;
  logic [2:0]  exp_cti;
  int          beat_cnt = 0, low_run = 0, frame_acks = 0;

  always @(negedge clk) begin
    if (rst) begin
      exp_adr = 0; prev_stall = 0; prev_stb = 0; prev_final = 0;
      beat_cnt = 0; low_run = 0;
    end else begin
      if (frame_done || prev_final) chk("frame_done", {31'd0, frame_done}, {31'd0, prev_final});
      prev_final = 1'b0;
      if (stb && prev_stall) begin
        chk("stall_adr", adr, prev_adr);
        chk("stall_dat", dat, prev_dat);
      end
      if (stb && ack) begin
        chk("adr_seq", adr, exp_adr);
`ifdef MIRE_GEN_CTI_EN
        exp_cti = (beat_cnt == 7 || adr == 32'h1FC) ? 3'b111 : 3'b010;
`else
        exp_cti = 3'b000;
`endif
        chk("cti8", {29'd0, cti}, {29'd0, exp_cti});
        mem[adr[8:2]] = dat;
        last_ack_adr  = adr;
        prev_final    = (adr == 32'h1FC);
        exp_adr       = prev_final ? 32'h0 : exp_adr + 32'd4;
        beat_cnt++;
        frame_acks++;
      end
      if (prev_stb && !stb) begin
        if (chk_gap) chk("burst_len", beat_cnt, 8);
        beat_cnt = 0;
        low_run  = 1;
      end else if (!stb) begin
        low_run++;
      end else if (!prev_stb) begin
        if (chk_gap) chk("gap_len", low_run, 1);
      end
      prev_stall = stb && !ack;
      prev_adr   = adr;
      prev_dat   = dat;
      prev_stb   = stb;
    end
  end

  // monitor for the BURST=24 instance: cti and burst boundaries of frame 1
  int   n2 = 0, k2 = 0;
  int   gaps2 [6] = '{24, 48, 72, 96, 120, 128};
  logic prev_stb2 = 1'b0;
  logic [2:0] e2;

  always @(negedge clk) begin
    if (!rst) begin
      if (stb2 && ack2 && n2 < 128) begin
`ifdef MIRE_GEN_CTI_EN
        e2 = (((n2 + 1) % 24 == 0) || n2 == 127) ? 3'b111 : 3'b010;
`else
        e2 = 3'b000;
`endif
        chk($sformatf("cti24_beat%0d", n2), {29'd0, cti2}, {29'd0, e2});
        n2++;
      end
      if (prev_stb2 && !stb2 && k2 < 6) begin
        chk($sformatf("burst24_end%0d", k2), n2, gaps2[k2]);
        k2++;
      end
      prev_stb2 = stb2;
    end
  end

  task automatic wait_fd();
    int i;
    for (i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (frame_done) break;
    end
    if (i == 5000) begin
      total++; bad++;
      $display("FAIL wait_frame_done: got timeout expected pulse");
    end
  endtask

  task automatic wait_ack_adr(input logic [31:0] a);
    int i;
    for (i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (stb && ack && adr == a) break;
    end
    if (i == 5000) begin
      total++; bad++;
      $display("FAIL wait_ack_adr: got timeout expected ack at %h", a);
    end
  endtask

  task automatic wait_stb(input logic lvl);
    int i;
    for (i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (stb == lvl) break;
    end
    if (i == 1000) begin
      total++; bad++;
      $display("FAIL wait_stb: got timeout expected stb=%0d", lvl);
    end
  endtask

  typedef struct {
    logic [1:0]  mode;
    int          x;
    int          y;
    logic [31:0] exp;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];
  int   nd;

  initial begin
    vecs[0]  = '{2'd0, 16, 1, 32'h00FFFFFF};
    vecs[1]  = '{2'd0,  5, 1, 32'h00000000};
    vecs[2]  = '{2'd0,  5, 0, 32'h00FFFFFF};
    vecs[3]  = '{2'd0,  0, 2, 32'h00FFFFFF};
    vecs[4]  = '{2'd0, 31, 3, 32'h00000000};
    vecs[5]  = '{2'd1,  0, 0, 32'h00000000};
    vecs[6]  = '{2'd1,  3, 2, 32'h00000000};
    vecs[7]  = '{2'd1,  4, 0, 32'h000000FF};
    vecs[8]  = '{2'd1,  7, 1, 32'h000000FF};
    vecs[9]  = '{2'd1,  8, 0, 32'h0000FF00};
    vecs[10] = '{2'd1, 12, 0, 32'h0000FFFF};
    vecs[11] = '{2'd1, 16, 3, 32'h00FF0000};
    vecs[12] = '{2'd1, 20, 0, 32'h00FF00FF};
    vecs[13] = '{2'd1, 24, 0, 32'h00FFFF00};
    vecs[14] = '{2'd1, 28, 0, 32'h00FFFFFF};
    vecs[15] = '{2'd1, 31, 3, 32'h00FFFFFF};
    vecs[16] = '{2'd2,  5, 0, 32'h00050505};
    vecs[17] = '{2'd2, 31, 2, 32'h001F1F1F};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_stb", {31'd0, stb}, 32'd0);
    chk("rst_cyc", {31'd0, cyc}, 32'd0);
    chk("rst_adr", adr, 32'h0);
    chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
    chk("const_we_sel_bte", {25'd0, we, sel, bte}, {25'd0, 1'b1, 4'hF, 2'b00});

    // acks while idle must not move anything
    force_ack = 1'b1;
    repeat (4) @(negedge clk);
    chk("idle_ack_adr", adr, 32'h0);
    chk("idle_ack_stb", {31'd0, stb}, 32'd0);
    force_ack = 1'b0;

    // first frame, grid, ack every cycle
    frame_acks = 0;
    en = 1'b1;
    repeat (2) @(negedge clk);
    chk_gap = 1'b1;
    wait_fd();
    chk("frame1_acks", frame_acks, 128);
    for (int i = 0; i < 128; i++) golden[i] = mem[i];

    // pattern table; a mode change waits out the current frame plus one
    for (int i = 0; i < NV; i++) begin
      if (vecs[i].mode != mode) begin
        mode = vecs[i].mode;
        wait_fd();
        wait_fd();
      end
      chk($sformatf("pix_m%0d_x%0d_y%0d", vecs[i].mode, vecs[i].x, vecs[i].y),
          mem[vecs[i].y * 32 + vecs[i].x], vecs[i].exp);
    end

    // random stalls: same frame as the stall-free grid run
    mode = 2'd0;
    ack_pct = 30;
    wait_fd();
    wait_fd();
    nd = 0;
    for (int i = 0; i < 128; i++) if (mem[i] !== golden[i]) nd++;
    chk("stall_frame_diffs", nd, 0);
    ack_pct = 100;

    // mode change mid-frame takes effect only at the next frame
    wait_ack_adr(32'hA0);
    mode  = 2'd3;
    color = 24'h123456;
    wait_fd();
    nd = 0;
    for (int i = 0; i < 128; i++) if (mem[i] !== golden[i]) nd++;
    chk("midframe_mode_diffs", nd, 0);
    wait_fd();
    nd = 0;
    for (int i = 0; i < 128; i++) if (mem[i] !== 32'h00123456) nd++;
    chk("solid_frame_diffs", nd, 0);

    // en dropped mid-burst: burst finishes, then resume from the next pixel
    wait_ack_adr(32'hAC);
    en = 1'b0;
    chk_gap = 1'b0;
    wait_stb(1'b0);
    chk("en_drop_last_adr", last_ack_adr, 32'hBC);
    repeat (5) @(negedge clk);
    chk("parked_stb", {31'd0, stb}, 32'd0);
    chk("parked_adr", adr, 32'hC0);
    en = 1'b1;
    wait_stb(1'b1);
    chk("resume_adr", adr, 32'hC0);
    repeat (2) @(negedge clk);
    chk_gap = 1'b1;

    // reset in the middle of a burst
    wait_ack_adr(32'h14);
    chk_gap = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_stb", {31'd0, stb}, 32'd0);
    chk("midrst_cyc", {31'd0, cyc}, 32'd0);
    chk("midrst_adr", adr, 32'h0);
    rst = 1'b0;
    wait_stb(1'b1);
    chk("post_rst_adr", adr, 32'h0);
    chk("post_rst_dat", dat, 32'h00123456);

    chk("burst24_count", k2, 6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mire_gen.md
Name: mire_gen

Overview:
- Parametrised test-pattern generator and Wishbone master. Writes one full frame of HDISP x VDISP 32-bit pixels (0x00RRGGBB) into the framebuffer in SDRAM, then starts the next frame.
- Successor to the fixed-grid pattern writer. Adds:
  - four selectable patterns;
  - configurable grid pitch, burst length and base address;
  - an enable input;
  - a frame-done pulse.

Parameters:
- HDISP, 800, active pixels per line
- VDISP, 480, active lines per frame
- BURST, 64, maximum acknowledged beats per bus cycle (>=1)
- GRID, 16, grid pitch in pixels for mode 0 (power of 2)
- BASE_ADR, 32'h0, byte address of pixel (0,0)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- en  in  1  run request
- mode  in  2  pattern select, sampled at frame start
- color  in  24  solid colour for mode 3, sampled at frame start
- wshb_cyc  out  1  Wishbone cycle
- wshb_stb  out  1  Wishbone strobe
- wshb_we  out  1  constant 1
- wshb_sel  out  4  constant 4'hF
- wshb_adr  out  32  byte address
- wshb_dat_ms  out  32  write data
- wshb_cti  out  3  cycle type
- wshb_bte  out  2  constant 0
- wshb_ack  in  1  slave acknowledge
- frame_done  out  1  one-cycle pulse after last pixel acked

Behaviour:
- Interface decided: one clock `clk`; `rst` is synchronous, active-high.
- Reset values:
  - cyc=stb=0, adr=BASE_ADR, frame_done=0;
  - x=y=0, beat counter=0;
  - FSM=IDLE; latched mode=0, latched colour=0.
- Position and address:
  - Counters x in [0,HDISP-1] and y in [0,VDISP-1], width $clog2 of each.
  - adr = BASE_ADR + 4*(y*HDISP+x). Maintain it incrementally (+4 per ack, reload BASE_ADR at frame wrap); do not multiply.
- FSM states: IDLE, BURST, GAP.
  - IDLE: stb=cyc=0. When en=1 and (x,y)=(0,0), latch mode and colour and go to BURST. If en=1 mid-frame (resuming), go straight to BURST without latching.
  - BURST: stb=cyc=1. adr and dat_ms held stable until ack. Each ack advances x (wrapping to 0 with y+1 at HDISP-1) and increments the beat counter.
    - Go to GAP on the ack of beat BURST-1.
    - Go to GAP on the ack of the last pixel of the frame, even if the burst is short.
  - GAP: stb=cyc=0 for exactly one cycle, beat counter cleared. Then:
    - to BURST if en=1 and the frame is not complete;
    - to IDLE otherwise.
    - Frame complete: re-latch mode/colour, then BURST if en=1, else IDLE.
- Frame wrap: ack of pixel (HDISP-1,VDISP-1) sets x=y=0 and adr=BASE_ADR, and pulses frame_done high in the next cycle.
- en deassert while in BURST: the current burst still runs to completion. The block then parks in IDLE keeping x, y and adr, and resumes from that position.
- dat_ms is combinational from x, y and the latched mode:
  - mode 0 grid: 32'h00FFFFFF if x%GRID==0 or y%GRID==0, else 0.
  - mode 1 colour bars: bar index b = x*8/HDISP, constant divide. Colour 0x00RRGGBB with R=b[2]?FF:00, G=b[1]?FF:00, B=b[0]?FF:00.
  - mode 2 gradient: gray g = x[7:0]; dat = {8'h0,g,g,g}.
  - mode 3 solid: {8'h0, latched colour}.
- ack while stb=0 is ignored.
- rst asserted mid-burst: all state returns to reset values on the next edge; the bus drops cyc/stb immediately.

Optional Feature:
- MIRE_GEN_CTI_EN
  - Defined: registered-feedback incrementing burst. cti=3'b010 on every beat except the last beat of the burst (beat BURST-1 or frame-last pixel), which carries 3'b111. bte=0.
  - Undefined: cti=3'b000 (classic) on every beat.
- Timing and everything else identical either way.

Test Plan:
- Parameters HDISP=32, VDISP=4, BURST=8, GRID=16; mode=0, en=1, slave acks every cycle:
  - 128 acked writes, adrs 0x000..0x1FC, then frame_done one pulse;
  - stb low exactly one cycle after every 8 acks;
  - pixel (16,1)=0x00FFFFFF, pixel (5,1)=0.
- mode=1, HDISP=32: pixels x=0..3 = 0x00000000, x=4..7 = 0x000000FF, x=28..31 = 0x00FFFFFF.
- Random ack stalls (ack 30%): adr and dat_ms unchanged while stb=1 and ack=0; final frame contents identical to the no-stall run.
- BURST=24, frame of 128 pixels: last burst is 8 beats. With MIRE_GEN_CTI_EN, cti=3'b111 only on beats 23, 47, 71, 95, 119 and 127.
- en dropped at beat 3 of the burst covering pixel 40: writes continue to pixel 47, then stb=0. en re-raised: next adr=0xC0 (pixel 48).
- mode changed 0→3 with color=24'h123456 mid-frame: remainder of the frame stays grid; next frame is all 0x00123456. rst mid-burst: stb=0 and adr=0 one cycle later.
